// File: rtl/hazard_if.sv
// Hazard-unit signal bundle: ID/EX state and operands in, pipeline enables and stats out.
interface hazard_if #(
    parameter int unsigned REG_AW = 3,
    parameter int unsigned CNT_W  = 16
);
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_rs_used;
    logic              id_rt_used;
    logic              idex_mem_read;
    logic              idex_reg_write;
    logic [REG_AW-1:0] idex_wr_addr;
    logic              idex_halt;
    logic              ex_branch_taken;
    logic              mem_busy;

    logic              pc_write_en;
    logic              ifid_write_en;
    logic              ifid_flush;
    logic              idex_flush;
    logic              pipe_freeze;
    logic              halted;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    // Pipeline side: supplies stage state, consumes the controls.
    modport master (
        output id_rs, id_rt, id_rs_used, id_rt_used, idex_mem_read, idex_reg_write,
               idex_wr_addr, idex_halt, ex_branch_taken, mem_busy,
        input  pc_write_en, ifid_write_en, ifid_flush, idex_flush, pipe_freeze, halted,
               stall_cnt, flush_cnt
    );

    // Hazard unit side.
    modport slave (
        input  id_rs, id_rt, id_rs_used, id_rt_used, idex_mem_read, idex_reg_write,
               idex_wr_addr, idex_halt, ex_branch_taken, mem_busy,
        output pc_write_en, ifid_write_en, ifid_flush, idex_flush, pipe_freeze, halted,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard/stall controller: memory-wait freeze, halt drain, branch flush,
// load-use stall, plus saturating stall/flush statistics.
module hazard_unit #(
    parameter int unsigned REG_AW       = 3,
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 16
) (
    input logic    clk,
    input logic    rst,
    hazard_if.slave bus
);

    typedef enum logic [1:0] {StRun, StDrain, StHalted} stateT;

    localparam logic [2:0] DrainInit = 3'(DRAIN_CYCLES - 1);

    stateT            stateQ, stateD;
    logic [2:0]       drainQ, drainD;
    logic [CNT_W-1:0] stallQ, flushQ;

    logic loadUse;
    logic countStall;
    logic countFlush;
    logic pcWe, ifidWe, ifidFlush, idexFlush, freeze, haltedOut;

    // Load in ID/EX whose destination is read by the ID instruction (r0 included).
    assign loadUse = bus.idex_mem_read && bus.idex_reg_write &&
                     ((bus.id_rs_used && (bus.id_rs == bus.idex_wr_addr)) ||
                      (bus.id_rt_used && (bus.id_rt == bus.idex_wr_addr)));

    // Control outputs and next state; defaults are the squash-everything reset controls.
    always_comb begin
        pcWe       = 1'b0;
        ifidWe     = 1'b0;
        ifidFlush  = 1'b1;
        idexFlush  = 1'b1;
        freeze     = 1'b0;
        haltedOut  = 1'b0;
        countStall = 1'b0;
        countFlush = 1'b0;
        stateD     = stateQ;
        drainD     = drainQ;
        if (rst) begin
            unique case (stateQ)
                StRun: begin
                    if (bus.mem_busy) begin
                        // Freeze wins over everything; nothing else is looked at.
                        freeze     = 1'b1;
                        ifidFlush  = 1'b0;
                        idexFlush  = 1'b0;
                        countStall = 1'b1;
                    end else if (bus.idex_halt) begin
                        drainD = DrainInit;
                        stateD = (DRAIN_CYCLES == 1) ? StHalted : StDrain;
                    end else if (bus.ex_branch_taken) begin
                        // Squashed ID instruction makes any load-use moot.
                        pcWe       = 1'b1;
                        ifidWe     = 1'b1;
                        countFlush = 1'b1;
                    end else if (loadUse) begin
                        ifidFlush  = 1'b0;
                        countStall = 1'b1;
                    end else begin
                        pcWe      = 1'b1;
                        ifidWe    = 1'b1;
                        ifidFlush = 1'b0;
                        idexFlush = 1'b0;
                    end
                end
                StDrain: begin
                    if (bus.mem_busy) begin
                        freeze = 1'b1;
                    end else if (drainQ == 3'd0) begin
                        stateD = StHalted;
                    end else begin
                        drainD = drainQ - 3'd1;
                    end
                end
                StHalted: begin
                    haltedOut = 1'b1;
                end
                default: begin
                    stateD = StRun;
                end
            endcase
        end
    end

    // State, drain counter and saturating statistics.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ <= StRun;
            drainQ <= 3'd0;
            stallQ <= '0;
            flushQ <= '0;
        end else begin
            stateQ <= stateD;
            drainQ <= drainD;
            if (countStall && (stallQ != '1)) stallQ <= stallQ + CNT_W'(1);
            if (countFlush && (flushQ != '1)) flushQ <= flushQ + CNT_W'(1);
        end
    end

    assign bus.pc_write_en   = pcWe;
    assign bus.ifid_write_en = ifidWe;
    assign bus.ifid_flush    = ifidFlush;
    assign bus.idex_flush    = idexFlush;
    assign bus.pipe_freeze   = freeze;
    assign bus.halted        = haltedOut;
    assign bus.stall_cnt     = stallQ;
    assign bus.flush_cnt     = flushQ;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: behavioural model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_hazard_unit;

    localparam int unsigned REG_AW = 3;
    localparam int unsigned DRAIN  = 3;
    localparam int unsigned CNT_W  = 16;
    localparam int          CMAX   = 65535;

    logic clk = 1'b0;
    logic rst = 1'b0;

    hazard_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) hif ();

    hazard_unit #(.REG_AW(REG_AW), .DRAIN_CYCLES(DRAIN), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (hif)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0=running, 1=draining, 2=halted; drain = remaining drain cycles.
    int mPhase = 0;
    int mLeft  = 0;
    int mStall = 0;
    int mFlush = 0;

    function automatic logic modelLoadUse();
        return hif.idex_mem_read && hif.idex_reg_write &&
               ((hif.id_rs_used && hif.id_rs == hif.idex_wr_addr) ||
                (hif.id_rt_used && hif.id_rt == hif.idex_wr_addr));
    endfunction

    // Expected {pc_we, ifid_we, ifid_flush, idex_flush, freeze, halted}.
    function automatic logic [5:0] expCtl();
        if (!rst)                return 6'b001100;
        if (mPhase == 2)         return 6'b001101;
        if (mPhase == 1)         return {4'b0011, hif.mem_busy, 1'b0};
        if (hif.mem_busy)        return 6'b000010;
        if (hif.idex_halt)       return 6'b001100;
        if (hif.ex_branch_taken) return 6'b111100;
        if (modelLoadUse())      return 6'b000100;
        return 6'b110000;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mPhase <= 0;
            mLeft  <= 0;
            mStall <= 0;
            mFlush <= 0;
        end else if (mPhase == 0) begin
            if (hif.mem_busy) begin
                mStall <= (mStall < CMAX) ? mStall + 1 : CMAX;
            end else if (hif.idex_halt) begin
                // Total drain time is DRAIN cycles of non-busy progress.
                mLeft  <= DRAIN;
                mPhase <= (DRAIN == 1) ? 2 : 1;
            end else if (hif.ex_branch_taken) begin
                mFlush <= (mFlush < CMAX) ? mFlush + 1 : CMAX;
            end else if (modelLoadUse()) begin
                mStall <= (mStall < CMAX) ? mStall + 1 : CMAX;
            end
        end else if (mPhase == 1 && !hif.mem_busy) begin
            if (mLeft <= 1) mPhase <= 2;
            else            mLeft  <= mLeft - 1;
        end
    end

    always @(negedge clk) begin
        logic [5:0] e;
        e = expCtl();
        chk("pc_write_en", hif.pc_write_en, e[5]);
        chk("ifid_write_en", hif.ifid_write_en, e[4]);
        chk("ifid_flush", hif.ifid_flush, e[3]);
        chk("idex_flush", hif.idex_flush, e[2]);
        chk("pipe_freeze", hif.pipe_freeze, e[1]);
        chk("halted", hif.halted, e[0]);
        chk("stall_cnt", hif.stall_cnt, 32'(rst ? mStall : 0));
        chk("flush_cnt", hif.flush_cnt, 32'(rst ? mFlush : 0));
    end

    task automatic setIn(input int rs, input int rt, input bit rsu, input bit rtu, input bit mr,
                         input bit rw, input int wa, input bit hlt, input bit br, input bit busy);
        hif.id_rs           = REG_AW'(rs);
        hif.id_rt           = REG_AW'(rt);
        hif.id_rs_used      = rsu;
        hif.id_rt_used      = rtu;
        hif.idex_mem_read   = mr;
        hif.idex_reg_write  = rw;
        hif.idex_wr_addr    = REG_AW'(wa);
        hif.idex_halt       = hlt;
        hif.ex_branch_taken = br;
        hif.mem_busy        = busy;
    endtask

    task automatic idle();
        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        idle();
        rst = 1'b0;
        repeat (2) tick();
        chk("rst pc_we", hif.pc_write_en, 0);
        chk("rst ifid_we", hif.ifid_write_en, 0);
        chk("rst ifid_flush", hif.ifid_flush, 1);
        chk("rst idex_flush", hif.idex_flush, 1);
        chk("rst halted", hif.halted, 0);
        chk("rst stall_cnt", hif.stall_cnt, 0);
        rst = 1'b1;

        // T1: load-use on rs
        setIn(3, 0, 1, 0, 1, 1, 3, 0, 0, 0);
        #2;
        chk("T1 pc_we", hif.pc_write_en, 0);
        chk("T1 ifid_we", hif.ifid_write_en, 0);
        chk("T1 idex_flush", hif.idex_flush, 1);
        chk("T1 ifid_flush", hif.ifid_flush, 0);
        tick();
        chk("T1 stall_cnt", hif.stall_cnt, 1);

        // T2: matching registers but not used
        setIn(3, 3, 0, 0, 1, 1, 3, 0, 0, 0);
        #2;
        chk("T2 pc_we", hif.pc_write_en, 1);
        chk("T2 ifid_we", hif.ifid_write_en, 1);
        tick();
        chk("T2 stall_cnt", hif.stall_cnt, 1);

        // T3: branch beats load-use
        setIn(3, 0, 1, 0, 1, 1, 3, 0, 1, 0);
        #2;
        chk("T3 pc_we", hif.pc_write_en, 1);
        chk("T3 ifid_flush", hif.ifid_flush, 1);
        chk("T3 idex_flush", hif.idex_flush, 1);
        tick();
        chk("T3 flush_cnt", hif.flush_cnt, 1);
        chk("T3 stall_cnt", hif.stall_cnt, 1);

        // T4: memory wait holds a pending branch for 3 cycles
        setIn(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("T4 freeze", hif.pipe_freeze, 1);
            chk("T4 pc_we", hif.pc_write_en, 0);
            chk("T4 ifid_flush", hif.ifid_flush, 0);
            tick();
        end
        chk("T4 stall_cnt", hif.stall_cnt, 4);
        hif.mem_busy = 1'b0;
        #2;
        chk("T4 branch pc_we", hif.pc_write_en, 1);
        chk("T4 branch flush", hif.idex_flush, 1);
        tick();
        chk("T4 flush_cnt", hif.flush_cnt, 2);
        idle();
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            if (mPhase == 2 && $urandom_range(0, 9) == 0) begin
                doReset();
            end else begin
                setIn($urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom),
                      1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 7),
                      $urandom_range(0, 99) == 0, $urandom_range(0, 5) == 0,
                      $urandom_range(0, 4) == 0);
                tick();
            end
        end

        // T5: halt drain stretched by one busy cycle
        idle();
        doReset();
        hif.idex_halt = 1'b1;
        tick();
        idle();
        tick();
        hif.mem_busy = 1'b1;
        #2;
        chk("T5 drain freeze", hif.pipe_freeze, 1);
        tick();
        hif.mem_busy = 1'b0;
        tick();
        chk("T5 halted early", hif.halted, 0);
        tick();
        chk("T5 halted", hif.halted, 1);
        for (int i = 0; i < 20; i++) begin
            setIn($urandom_range(0, 7), 0, 1, 0, 1, 1, $urandom_range(0, 7), 0, 1'($urandom),
                  1'($urandom));
            tick();
        end
        chk("T5 halted held", hif.halted, 1);
        chk("T5 pc_we", hif.pc_write_en, 0);

        // T6: asynchronous reset mid-drain
        idle();
        doReset();
        hif.ex_branch_taken = 1'b1;
        tick();
        hif.ex_branch_taken = 1'b0;
        hif.mem_busy = 1'b1;
        tick();
        hif.mem_busy = 1'b0;
        hif.idex_halt = 1'b1;
        tick();
        idle();
        #2;
        rst = 1'b0;
        #1;
        chk("T6 pc_we", hif.pc_write_en, 0);
        chk("T6 ifid_flush", hif.ifid_flush, 1);
        chk("T6 idex_flush", hif.idex_flush, 1);
        chk("T6 halted", hif.halted, 0);
        chk("T6 stall_cnt", hif.stall_cnt, 0);
        chk("T6 flush_cnt", hif.flush_cnt, 0);
        tick();
        rst = 1'b1;
        #2;
        chk("T6 run pc_we", hif.pc_write_en, 1);
        chk("T6 run ifid_we", hif.ifid_write_en, 1);

        // T7: stall counter saturation
        tick();
        hif.mem_busy = 1'b1;
        repeat (CMAX + 5) tick();
        chk("T7 stall_cnt sat", hif.stall_cnt, 32'hFFFF);
        tick();
        chk("T7 stall_cnt hold", hif.stall_cnt, 32'hFFFF);
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
